// File: rtl/priority_2to4_decoder_seq_pkg.sv
// Shared types for the priority decoder: the occupancy enum, the decoded token
// and the decode function.
package prio_pkg;

    localparam int IDX_W = 2;
    localparam int OH_W  = 2 ** IDX_W;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_state_t;

    typedef struct packed {
        logic [OH_W-1:0] onehot;
        logic            error;
    } tok_t;

    // An error token carries no index, so its one-hot is all zero.
    function automatic tok_t decode_tok(input logic [IDX_W-1:0] idx, input logic err);
        tok_t t;
        t.error  = err;
        t.onehot = err ? '0 : (OH_W'(1) << idx);
        return t;
    endfunction

endpackage

// File: rtl/priority_2to4_decoder_seq_if.sv
// Token link between the encoder-side stage, the decoder and its one-hot consumer.
interface priority_2to4_decoder_seq_if;
    import prio_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_error;
    logic             out_valid;
    logic             out_ready;
    logic [OH_W-1:0]  out_onehot;
    logic             out_error;

    modport master (
        output in_valid, in_idx, in_error, out_ready,
        input  in_ready, out_valid, out_onehot, out_error
    );

    modport slave (
        input  in_valid, in_idx, in_error, out_ready,
        output in_ready, out_valid, out_onehot, out_error
    );

endinterface

// File: rtl/priority_2to4_decoder_seq_skid_buf2.sv
// Two-entry valid/ready buffer of decoded tokens; keeps one token per cycle
// flowing while the consumer stalls, with in_ready taken straight from a register.
module skid_buf2
    import prio_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  tok_t in_data,
    output logic out_valid,
    input  logic out_ready,
    output tok_t out_data
);

    occ_state_t state;
    occ_state_t state_nx;
    tok_t       head;
    tok_t       tail;
    logic       rdy;
    logic       push;
    logic       pop;

    assign push = in_valid & rdy;
    assign pop  = out_valid & out_ready;

    // rdy is the registered image of next_state != TWO, so it is low during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            rdy   <= 1'b0;
        end else begin
            state <= state_nx;
            rdy   <= (state_nx != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                EMPTY: if (push) head <= in_data;
                ONE: begin
                    if (push && pop) head <= in_data;
                    else if (push)   tail <= in_data;
                end
                TWO:     if (pop) head <= tail;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (push) state_nx = ONE;
            ONE: begin
                if (push && !pop)      state_nx = TWO;
                else if (!push && pop) state_nx = EMPTY;
            end
            TWO:     if (pop) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = rdy;
        out_data  = head;
    end

endmodule

// File: rtl/priority_2to4_decoder_seq.sv
// Registered one-hot decoder for the priority encoder's {idx, error} code,
// buffered two deep, with debug counters of accepted and error tokens.
module priority_2to4_decoder_seq
    import prio_pkg::*;
#(
    parameter int ERR_CNT_W = 8,
    parameter int TOK_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    priority_2to4_decoder_seq_if.slave  bus,
    output logic [ERR_CNT_W-1:0]        err_cnt,
    output logic [TOK_CNT_W-1:0]        tok_cnt
);

    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] cnt,
                                                     input logic inc);
        return (inc && !(&cnt)) ? cnt + ERR_CNT_W'(1) : cnt;
    endfunction

    function automatic logic [TOK_CNT_W-1:0] wrap_inc(input logic [TOK_CNT_W-1:0] cnt);
        return cnt + TOK_CNT_W'(1);
    endfunction

    tok_t tok_in;
    tok_t tok_out;
    logic push;

    assign tok_in = decode_tok(bus.in_idx, bus.in_error);
    assign push   = bus.in_valid & bus.in_ready;

    skid_buf2 u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (tok_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (tok_out)
    );

    assign bus.out_onehot = tok_out.onehot;
    assign bus.out_error  = tok_out.error;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
            tok_cnt <= '0;
        end else if (push) begin
            err_cnt <= sat_add(err_cnt, bus.in_error);
            tok_cnt <= wrap_inc(tok_cnt);
        end
    end

endmodule
